// File: rtl/pdu_rb_arb.sv
// pdu_rb_arb: round-robin write-ownership arbiter and tail/head pointer controller for the shared PCIe ring buffer.
// Optional build macro PDU_RB_ARB_STATS_EN adds per-requester PDU/flit counters (stat_pdus, stat_flits).
module pdu_rb_arb #(
    parameter int NUM_REQ       = 2,
    parameter int PDU_AWIDTH    = 12,
    parameter int FLIT_W        = 514,
    parameter int MAX_PDU_FLITS = 25
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_almost_full,
    output logic [PDU_AWIDTH-1:0]          rb_base_addr,
    input  logic [NUM_REQ-1:0]             upd_valid,
    input  logic [NUM_REQ*PDU_AWIDTH-1:0]  upd_size,
    input  logic [NUM_REQ-1:0]             in_wr_en,
    input  logic [NUM_REQ*PDU_AWIDTH-1:0]  in_wr_addr,
    input  logic [NUM_REQ*FLIT_W-1:0]      in_wr_data,
    output logic                           rb_wr_en,
    output logic [PDU_AWIDTH-1:0]          rb_wr_addr,
    output logic [FLIT_W-1:0]              rb_wr_data,
    input  logic                           head_wr_valid,
    input  logic [PDU_AWIDTH-1:0]          head_wr_ptr,
    output logic                           tail_valid,
    output logic [PDU_AWIDTH-1:0]          tail_ptr,
    output logic [1:0]                     err_flags
`ifdef PDU_RB_ARB_STATS_EN
    ,
    output logic [NUM_REQ*32-1:0]          stat_pdus,
    output logic [NUM_REQ*32-1:0]          stat_flits
`endif
);

    localparam int OW = $clog2(NUM_REQ);
    localparam int AW = PDU_AWIDTH;

    // state    | meaning
    // ST_IDLE  | no owner; grant when a requester is pending and free >= MAX_PDU_FLITS
    // ST_GRANT | owner holds the write port; waiting for its upd_valid
    // ST_DRAIN | one cycle after the update so the owner's header write passes
    typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_DRAIN} state_t;

    state_t          state, state_nxt;
    logic [OW-1:0]   owner, rr_ptr, rr_nxt, pick_idx, cand_idx;
    logic            pick_found;
    logic [AW-1:0]   tail, head, free_cnt, own_size, tail_nxt;
    logic            free_ok, own_upd, stray_upd, oversize;
    logic            grant_go, upd_accept;
    logic [NUM_REQ-1:0] grant_mask, owner_bit;
    int              cand;

    // (tail - head) is the occupancy; its bitwise inverse is depth-1-occupancy
    assign free_cnt  = ~(tail - head);
    assign free_ok   = (32'(free_cnt) >= 32'(MAX_PDU_FLITS));
    assign own_size  = upd_size[owner*AW +: AW];
    assign own_upd   = upd_valid[owner];
    assign owner_bit = NUM_REQ'(1) << owner;
    assign stray_upd = (state == ST_GRANT) ? |(upd_valid & ~owner_bit) : |upd_valid;
    assign oversize  = ((32'(own_size) + 32'd1) > 32'(MAX_PDU_FLITS));
    assign tail_nxt  = tail + own_size + AW'(1);
    assign rr_nxt    = (owner == OW'(NUM_REQ - 1)) ? '0 : owner + OW'(1);
    assign grant_mask = ~(NUM_REQ'(1) << pick_idx);
    assign rb_base_addr = tail;

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(rr_ptr) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = OW'(cand);
            if (!pick_found && req_valid[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        grant_go   = 1'b0;
        upd_accept = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_found && free_ok) begin
                    grant_go  = 1'b1;
                    state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (own_upd) begin
                    upd_accept = 1'b1;
                    state_nxt  = ST_DRAIN;
                end
            end
            ST_DRAIN: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner           <= '0;
            rr_ptr          <= '0;
            tail            <= '0;
            head            <= '0;
            tail_valid      <= 1'b0;
            tail_ptr        <= '0;
            err_flags       <= 2'b00;
            req_almost_full <= '1;
        end else begin
            tail_valid <= 1'b0;
            if (head_wr_valid) begin
                head <= head_wr_ptr;
            end
            if (grant_go) begin
                owner           <= pick_idx;
                req_almost_full <= grant_mask;
            end
            if (upd_accept) begin
                tail            <= tail_nxt;
                tail_ptr        <= tail_nxt;
                tail_valid      <= 1'b1;
                rr_ptr          <= rr_nxt;
                req_almost_full <= '1;
                if (oversize) begin
                    err_flags[0] <= 1'b1;
                end
            end
            if (stray_upd) begin
                err_flags[1] <= 1'b1;
            end
        end
    end

    always_comb begin
        rb_wr_en   = 1'b0;
        rb_wr_addr = '0;
        rb_wr_data = '0;
        if (state != ST_IDLE) begin
            rb_wr_en   = in_wr_en[owner];
            rb_wr_addr = in_wr_addr[owner*AW +: AW];
            rb_wr_data = in_wr_data[owner*FLIT_W +: FLIT_W];
        end
    end

`ifdef PDU_RB_ARB_STATS_EN
    logic [31:0] pdu_cnt  [NUM_REQ];
    logic [31:0] flit_cnt [NUM_REQ];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                pdu_cnt[i]  <= '0;
                flit_cnt[i] <= '0;
            end
        end else if (upd_accept) begin
            pdu_cnt[owner]  <= pdu_cnt[owner] + 32'd1;
            flit_cnt[owner] <= flit_cnt[owner] + 32'(own_size) + 32'd1;
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
        assign stat_pdus[g*32 +: 32]  = pdu_cnt[g];
        assign stat_flits[g*32 +: 32] = flit_cnt[g];
    end
`endif

endmodule

// File: tb/tb_pdu_rb_arb.sv
// tb_pdu_rb_arb: directed checks of grant, write mux, tail/head arithmetic, errors and reset for pdu_rb_arb.
// Uses a 64-entry ring so the full and wrap cases are reachable in a few PDUs.
module tb_pdu_rb_arb;

    localparam int NR = 2;
    localparam int AW = 6;
    localparam int FW = 514;
    localparam int MX = 25;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_almost_full;
    logic [AW-1:0]     rb_base_addr;
    logic [NR-1:0]     upd_valid;
    logic [NR*AW-1:0]  upd_size;
    logic [NR-1:0]     in_wr_en;
    logic [NR*AW-1:0]  in_wr_addr;
    logic [NR*FW-1:0]  in_wr_data;
    logic              rb_wr_en;
    logic [AW-1:0]     rb_wr_addr;
    logic [FW-1:0]     rb_wr_data;
    logic              head_wr_valid;
    logic [AW-1:0]     head_wr_ptr;
    logic              tail_valid;
    logic [AW-1:0]     tail_ptr;
    logic [1:0]        err_flags;

    int n_chk = 0;
    int n_bad = 0;
    int cyc;

    pdu_rb_arb #(
        .NUM_REQ(NR), .PDU_AWIDTH(AW), .FLIT_W(FW), .MAX_PDU_FLITS(MX)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_almost_full(req_almost_full), .rb_base_addr(rb_base_addr),
        .upd_valid(upd_valid), .upd_size(upd_size),
        .in_wr_en(in_wr_en), .in_wr_addr(in_wr_addr), .in_wr_data(in_wr_data),
        .rb_wr_en(rb_wr_en), .rb_wr_addr(rb_wr_addr), .rb_wr_data(rb_wr_data),
        .head_wr_valid(head_wr_valid), .head_wr_ptr(head_wr_ptr),
        .tail_valid(tail_valid), .tail_ptr(tail_ptr), .err_flags(err_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_wr(input int r, input int addr, input logic [63:0] data);
        in_wr_en[r] = 1'b1;
        in_wr_addr[r*AW +: AW] = AW'(addr);
        in_wr_data[r*FW +: FW] = FW'(data);
    endtask

    task automatic upd_pulse(input int r, input int size);
        upd_valid = '0;
        upd_valid[r] = 1'b1;
        upd_size[r*AW +: AW] = AW'(size);
        step();
        upd_valid = '0;
    endtask

    task automatic head_pulse(input int ptr);
        head_wr_valid = 1'b1;
        head_wr_ptr   = AW'(ptr);
        step();
        head_wr_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    // waits (bounded) for any grant, then checks the gate pattern for the expected owner
    task automatic wait_grant(input int who, output int waited);
        logic [NR-1:0] exp_af;
        waited = 0;
        exp_af = '1;
        exp_af[who] = 1'b0;
        while (waited < 40 && req_almost_full == '1) begin
            step();
            waited++;
        end
        chk("grant_af", 64'(req_almost_full), 64'(exp_af));
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = '0; upd_valid = '0; upd_size = '0;
        in_wr_en = '0; in_wr_addr = '0; in_wr_data = '0;
        head_wr_valid = 1'b0; head_wr_ptr = '0;
        repeat (3) step();
        chk("rst_af", 64'(req_almost_full), 64'h3);
        chk("rst_base", 64'(rb_base_addr), 64'h0);
        chk("rst_wr_en", 64'(rb_wr_en), 64'h0);
        chk("rst_tail_valid", 64'(tail_valid), 64'h0);
        chk("rst_err", 64'(err_flags), 64'h0);
        rst_n = 1'b1;
        step();

        // single PDU from requester 0; requester 1 writes concurrently and must be dropped
        req_valid = 2'b01;
        wait_grant(0, cyc);
        chk("single_base", 64'(rb_base_addr), 64'h0);
        for (int a = 1; a <= 3; a++) begin
            drive_wr(0, a, 64'(a * 17));
            drive_wr(1, 40 + a, 64'hDEAD);
            #1;
            chk("single_wr_en", 64'(rb_wr_en), 64'h1);
            chk("single_wr_addr", 64'(rb_wr_addr), 64'(a));
            chk("single_wr_data", rb_wr_data[63:0], 64'(a * 17));
            step();
        end
        in_wr_en = '0;
        req_valid = '0;
        upd_pulse(0, 3);
        chk("single_tail_valid", 64'(tail_valid), 64'h1);
        chk("single_tail_ptr", 64'(tail_ptr), 64'h4);
        chk("single_base_after", 64'(rb_base_addr), 64'h4);
        chk("single_af_back", 64'(req_almost_full), 64'h3);
        drive_wr(0, 0, 64'h4EAD);
        #1;
        chk("drain_hdr_en", 64'(rb_wr_en), 64'h1);
        chk("drain_hdr_addr", 64'(rb_wr_addr), 64'h0);
        chk("drain_hdr_data", rb_wr_data[63:0], 64'h4EAD);
        step();
        chk("idle_tail_valid", 64'(tail_valid), 64'h0);
        chk("idle_wr_dropped", 64'(rb_wr_en), 64'h0);
        in_wr_en = '0;

        // round-robin with both requesting; grants 3 cycles apart
        do_reset();
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_grant(k % 2, cyc);
            if (k > 0) chk("rr_spacing", 64'(cyc), 64'h2);
            chk("rr_base", 64'(rb_base_addr), 64'(2 * k));
            upd_pulse(k % 2, 1);
        end
        req_valid = '0;

        // full: head at 0, 8-flit PDUs until free < 25
        do_reset();
        req_valid = 2'b01;
        for (int k = 0; k < 5; k++) begin
            wait_grant(0, cyc);
            chk("full_base", 64'(rb_base_addr), 64'(8 * k));
            upd_pulse(0, 7);
        end
        repeat (10) step();
        chk("full_hold_af", 64'(req_almost_full), 64'h3);
        chk("full_hold_base", 64'(rb_base_addr), 64'd40);
        head_pulse(40);
        wait_grant(0, cyc);
        chk("full_resume_base", 64'(rb_base_addr), 64'd40);

        // wrap: tail 62 + 5 -> 3, head moved in the same cycle to leave exactly 24 free
        upd_pulse(0, 21);
        wait_grant(0, cyc);
        chk("wrap_base62", 64'(rb_base_addr), 64'd62);
        head_wr_valid = 1'b1;
        head_wr_ptr   = AW'(28);
        upd_pulse(0, 4);
        head_wr_valid = 1'b0;
        chk("wrap_tail_valid", 64'(tail_valid), 64'h1);
        chk("wrap_tail_ptr", 64'(tail_ptr), 64'd3);
        repeat (6) step();
        chk("free24_no_grant", 64'(req_almost_full), 64'h3);
        head_pulse(29);
        wait_grant(0, cyc);
        chk("free25_grant_base", 64'(rb_base_addr), 64'd3);
        upd_pulse(0, 0);
        req_valid = '0;

        // errors: stray update from non-owner, then oversize from owner
        do_reset();
        req_valid = 2'b01;
        wait_grant(0, cyc);
        upd_pulse(1, 5);
        chk("stray_err", 64'(err_flags), 64'h2);
        chk("stray_no_tail", 64'(tail_valid), 64'h0);
        chk("stray_base", 64'(rb_base_addr), 64'h0);
        chk("stray_still_owner", 64'(req_almost_full), 64'h2);
        upd_pulse(0, 30);
        chk("oversize_err", 64'(err_flags), 64'h3);
        chk("oversize_tail", 64'(tail_ptr), 64'd31);

        // reset in the middle of a grant
        wait_grant(0, cyc);
        chk("regrant_base", 64'(rb_base_addr), 64'd31);
        drive_wr(0, 32, 64'h11);
        step();
        drive_wr(0, 33, 64'h22);
        step();
        rst_n = 1'b0;
        #1;
        chk("midrst_af", 64'(req_almost_full), 64'h3);
        chk("midrst_base", 64'(rb_base_addr), 64'h0);
        chk("midrst_err", 64'(err_flags), 64'h0);
        chk("midrst_wr_en", 64'(rb_wr_en), 64'h0);
        in_wr_en = '0;
        repeat (2) step();
        rst_n = 1'b1;
        wait_grant(0, cyc);
        chk("postrst_base", 64'(rb_base_addr), 64'h0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule
